// File: rtl/booth_pkg.sv
// Shared definitions for the radix-4 Booth multipliers: weight codes, FSM states
// and a sign-extension helper.
package booth_pkg;

  localparam logic [2:0] W_ZERO = 3'b000;
  localparam logic [2:0] W_P1   = 3'b001;
  localparam logic [2:0] W_P2   = 3'b010;
  localparam logic [2:0] W_M1   = 3'b111;
  localparam logic [2:0] W_M2   = 3'b110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Sign-extends the low `width` bits of val to 64 bits.
  function automatic logic [63:0] sext_to(input logic [63:0] val, input int width);
    logic signed [63:0] t;
    t = val << (64 - width);
    return t >>> (64 - width);
  endfunction

endpackage

// File: rtl/booth_seq_mult_if.sv
// Operand/product handshake bundle for booth_seq_mult, plus FSM state for observation.
// A transfer happens on a rising edge where valid & ready are both high; the
// sender holds its payload stable while valid is high and ready is low.
interface booth_seq_mult_if
  import booth_pkg::*;
#(
  parameter int W = 8
);
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] product;
  logic           busy;
  state_t         state;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, product, busy, state
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, product, busy, state
  );
endinterface

// File: rtl/booth_enc.sv
// Radix-4 Booth recoder: multiplier bit triple {b[2i+1], b[2i], b[2i-1]} to weight code.
module booth_enc
  import booth_pkg::*;
(
  input  logic [2:0] triple,
  output logic [2:0] code
);

  always_comb begin
    code = W_ZERO;
    case (triple)
      3'b000:  code = W_ZERO;
      3'b001:  code = W_P1;
      3'b010:  code = W_P1;
      3'b011:  code = W_P2;
      3'b100:  code = W_M2;
      3'b101:  code = W_M1;
      3'b110:  code = W_M1;
      3'b111:  code = W_ZERO;
      default: code = W_ZERO;
    endcase
  end

endmodule

// File: rtl/booth_seq_mult.sv
// Iterative radix-4 Booth signed multiplier: one Booth digit per cycle,
// shift-accumulated into a 2W-bit product register.
module booth_seq_mult
  import booth_pkg::*;
#(
  parameter int W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  booth_seq_mult_if.slave  bus
);

  localparam int NDIG = W / 2;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int PW   = 2 * W;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  state_t          state;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [PW-1:0]   acc;
  logic [CW-1:0]   cnt;

  logic [W:0]      b_ext;
  logic [2:0]      triple;
  logic [2:0]      code;
  logic [PW-1:0]   a_ext;
  logic [PW-1:0]   pp;
  logic [PW-1:0]   pp_sh;

  // b_ext carries the implicit b[-1] = 0 so digit i reads bits [2i+2:2i].
  assign b_ext  = {b_q, 1'b0};
  assign triple = b_ext[{cnt, 1'b0} +: 3];
  assign a_ext  = PW'(sext_to(64'(a_q), W));

  booth_enc u_enc (
    .triple (triple),
    .code   (code)
  );

  always_comb begin
    pp = '0;
    case (code)
      W_ZERO:  pp = '0;
      W_P1:    pp = a_ext;
      W_P2:    pp = a_ext << 1;
      W_M1:    pp = ~a_ext + PW'(1);
      W_M2:    pp = ~(a_ext << 1) + PW'(1);
      default: pp = '0;
    endcase
    pp_sh = pp << {cnt, 1'b0};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_q   <= '0;
      b_q   <= '0;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_q   <= bus.a;
            b_q   <= bus.b;
            acc   <= '0;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          // Top digit may overflow 2W bits; modulo wrap keeps the sum exact.
          acc <= acc + pp_sh;
          cnt <= cnt + CW'(1);
          if (cnt == LAST) state <= DONE;
        end
        DONE: begin
          if (bus.out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state == RUN) || (state == DONE);
  assign bus.product   = acc;
  assign bus.state     = state;

endmodule
